block_uart_serializer: RTL
==========================

// Module: block_uart_serializer
// PURPOSE
//  Output stage downstream of the fnet/ifnet cipher datapath.
//  Accepts 64-bit cipher result blocks over a valid/ready handshake and buffers them in a small block FIFO.
//  Serialises each block MSB byte first into the uart_tx START/BUSY interface.
//  Replaces the inline out_buffer/uart_write_state logic in top, and removes the fixed delay_cnt wait.
// PARAMETERS
//  DEPTH         2   block FIFO entries; power of 2, >=2
//  BUSY_TIMEOUT  16  cycles to wait for TX_BUSY to rise after TX_START before the byte is abandoned
//  GAP_CYCLES    0   idle cycles inserted after each byte completes; 0 = no gap
// PORTS
//  CLK         in   1             system clock
//  RST         in   1             synchronous active-high reset
//  IN_DATA     in   64            block to transmit; [63:56] goes out first
//  IN_VALID    in   1             IN_DATA valid
//  IN_READY    out  1             FIFO can accept; push = IN_VALID & IN_READY
//  TX_DATA     out  8             byte to uart_tx.DATA
//  TX_START    out  1             one-cycle start pulse to uart_tx.START
//  TX_BUSY     in   1             uart_tx.BUSY
//  FIFO_LEVEL  out  $clog2(DEPTH)+1  blocks stored, excluding the block being sent
//  BLOCK_DONE  out  1             one-cycle pulse after the 8th byte of a block completes
//  TX_TIMEOUT  out  1             one-cycle pulse when a byte is abandoned on BUSY_TIMEOUT
//  IDLE        out  1             FIFO empty and FSM in S_IDLE
// BEHAVIOUR
//  Reset and register timing
//   - Reset applies at the next CLK edge with RST high.
//   - Reset values: FIFO empty, state S_IDLE, TX_START=0, TX_DATA=8'h00, BLOCK_DONE=0, TX_TIMEOUT=0, FIFO_LEVEL=0.
//   - IN_READY=0 while RST is high, then !full. IDLE=1.
//   - All outputs are registered except IN_READY, FIFO_LEVEL and IDLE, which decode registered state.
//  FIFO
//   - Push on IN_VALID & IN_READY.
//   - When full, IN_READY=0 even if a pop happens in the same cycle; no same-cycle push/pop through a full FIFO.
//   - A push and pop together when neither full nor empty leave the level unchanged.
//   - Pointers wrap modulo DEPTH.
//  FSM
//   - S_IDLE: when FIFO is non-empty, pop the head into the 64-bit shift register, byte_idx<=0, go to S_SEND.
//   - S_SEND: wait while TX_BUSY=1. When TX_BUSY=0: TX_DATA<=shreg[63:56], TX_START<=1, timer<=0, go to S_WBUSY.
//   - S_WBUSY: TX_START<=0.
//       - TX_BUSY=1: go to S_WDONE.
//       - Otherwise timer++. At timer==BUSY_TIMEOUT-1: pulse TX_TIMEOUT and go to S_NEXT; the byte counts as sent.
//   - S_WDONE: when TX_BUSY=0, go to S_GAP with gap counter=0, or straight to S_NEXT if GAP_CYCLES==0.
//   - S_GAP: count GAP_CYCLES cycles, then go to S_NEXT.
//   - S_NEXT: shreg<=shreg<<8, byte_idx++.
//       - If byte_idx was 7: pulse BLOCK_DONE and go to S_IDLE.
//       - Otherwise go to S_SEND.
//  Latency and throughput
//   - Push accepted at edge N into an empty FIFO with idle TX: pop at edge N+1, TX_START high in cycle N+3.
//   - Back-to-back blocks: next pop occurs in the S_IDLE cycle right after BLOCK_DONE; no byte is skipped or duplicated.
//  Boundary cases
//   - TX_START is never asserted on consecutive cycles.
//   - TX_DATA is held stable from the start pulse until the FSM leaves S_WDONE.
//   - RST mid-block: the partial block and all queued blocks are discarded; TX_START=0 after that edge. A byte already latched by uart_tx completes on its own.
//   - TX_BUSY high while in S_IDLE (external use of the UART) is ignored until S_SEND.
// TESTING
//  T1
//   - Stimulus: push 64'h3031323334353637 into an idle block; BUSY model rises 1 cycle after START and stays high 10 cycles.
//   - Required: TX bytes 30,31,...,37 in order; exactly 8 START pulses; 1 BLOCK_DONE after byte 37.
//  T2
//   - Stimulus: hold IN_VALID high with 3 distinct blocks, DEPTH=2.
//   - Required: IN_READY drops when FIFO_LEVEL==2 with the first block in flight; 24 bytes out in push order; FIFO_LEVEL ends at 0.
//  T3
//   - Stimulus: TX_BUSY tied 0.
//   - Required: each byte gives TX_TIMEOUT 16 cycles after its START; 8 timeouts then BLOCK_DONE; FSM back in S_IDLE, IDLE=1.
//  T4
//   - Stimulus: assert RST for 1 cycle after byte 3 of block A, with block B queued.
//   - Required: no further START for A or B; FIFO_LEVEL=0; a new block C then sends all 8 bytes correctly.
//  T5
//   - Stimulus: GAP_CYCLES=4.
//   - Required: at least 4 cycles between BUSY falling and the next START.
//   - Also check: TX_START never high two cycles in a row (assertion over all tests).
//  T6
//   - Stimulus: TX_BUSY held high before the first push.
//   - Required: no START until TX_BUSY falls; then the normal sequence follows.

Source files
------------

// File: rtl/block_uart_serializer_if.sv
// Block-in / byte-out handshake bundle between the cipher datapath, the serializer and uart_tx.
interface block_uart_serializer_if;
  logic [63:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  TX_DATA;
  logic        TX_START;
  logic        TX_BUSY;

  // Producer side: cipher datapath and the uart_tx BUSY return
  modport master (
    output IN_DATA, IN_VALID, TX_BUSY,
    input  IN_READY, TX_DATA, TX_START
  );

  // Serializer side
  modport slave (
    input  IN_DATA, IN_VALID, TX_BUSY,
    output IN_READY, TX_DATA, TX_START
  );
endinterface

// File: rtl/block_uart_serializer.sv
// Buffers 64-bit cipher blocks and feeds them MSB byte first into uart_tx via START/BUSY.
module block_uart_serializer #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  block_uart_serializer_if.slave    bus,
  output logic [$clog2(DEPTH):0]    FIFO_LEVEL,
  output logic                      BLOCK_DONE,
  output logic                      TX_TIMEOUT,
  output logic                      IDLE
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WBUSY, S_WDONE, S_GAP, S_NEXT
  } state_t;

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full_c, empty_c, push_c, pop_c;

  state_t           state_q, state_d;
  logic [63:0]      shreg_q, shreg_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             block_done_q, block_done_d;
  logic             tx_timeout_q, tx_timeout_d;

  // A full FIFO refuses input even if it is being popped this cycle
  assign full_c       = (level == LVL_FULL);
  assign empty_c      = (level == '0);
  assign bus.IN_READY = !RST && !full_c;
  assign push_c       = bus.IN_VALID && bus.IN_READY;

  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_START = tx_start_q;
  assign FIFO_LEVEL   = level;
  assign BLOCK_DONE   = block_done_q;
  assign TX_TIMEOUT   = tx_timeout_q;
  assign IDLE         = empty_c && (state_q == S_IDLE);

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge CLK) begin
    if (push_c) mem[wr_ptr] <= bus.IN_DATA;
  end

  // Serializer state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      byte_idx_q   <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      block_done_q <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_idx_q   <= byte_idx_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      block_done_q <= block_done_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  // Byte sequencing: pop, start, wait for BUSY rise/fall, optional gap, advance
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_idx_d   = byte_idx_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    block_done_d = 1'b0;
    tx_timeout_d = 1'b0;
    pop_c        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c      = 1'b1;
          shreg_d    = mem[rd_ptr];
          byte_idx_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.TX_BUSY) begin
          tx_data_d  = shreg_q[63:56];
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = S_WBUSY;
        end
      end
      S_WBUSY: begin
        if (bus.TX_BUSY) begin
          state_d = S_WDONE;
        end else if (timer_q == TMR_LAST) begin
          tx_timeout_d = 1'b1;
          state_d      = S_NEXT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WDONE: begin
        if (!bus.TX_BUSY) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_NEXT : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_NEXT;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      S_NEXT: begin
        shreg_d    = {shreg_q[55:0], 8'h00};
        byte_idx_d = byte_idx_q + 3'd1;
        if (byte_idx_q == 3'd7) begin
          block_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
